// File: rtl/uart_tx_mmio_if.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio_if
// Data-memory bus between the CPU load/store port and the UART transmitter.
//   we    : store strobe, one cycle per access
//   re    : load strobe, one cycle per access
//   addr  : word offset (0 = TXDATA, 1 = STATUS, 2..3 reserved)
//   wdata : store data
//   rdata : load data, registered in the slave
// ---------------------------------------------------------------------------
interface uart_tx_mmio_if;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output re, output addr, output wdata, input rdata);
  modport slave  (input we, input re, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped UART transmitter. CPU stores to TXDATA are queued in a byte
// FIFO and serialised on txd as 8N1 frames (8E1 when UART_TX_PARITY_EN is
// defined). STATUS can be polled; irq is high when nothing is left to send.
//
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after data bit 7,
// STATUS bit4 reads 1).
//
// Parameters:
//   DIVISOR    : clock cycles per bit, 2..65535
//   FIFO_DEPTH : FIFO entries, power of two, 2..64
// Ports:
//   sysclk : system clock, rising edge
//   nrst   : asynchronous active-low reset
//   bus    : slave side of the data-memory bus (we/re/addr/wdata/rdata)
//   txd    : serial output, idle high, registered
//   irq    : level interrupt, FIFO empty and transmitter idle, registered
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
  parameter int DIVISOR    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          sysclk,
  input  logic          nrst,
  uart_tx_mmio_if.slave bus,
  output logic          txd,
  output logic          irq
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [15:0]     DIV_M1   = 16'(DIVISOR - 1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // STATUS layout; the FIFO count field saturates at 15 for deep FIFOs.
  function automatic logic [31:0] status_word(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic       ovf,
    input logic       par,
    input logic [7:0] cnt
  );
    logic [3:0] sat;
    if (cnt > 8'd15) begin
      sat = 4'hF;
    end else begin
      sat = cnt[3:0];
    end
    return {20'h00000, sat, 3'b000, par, ovf, busy, empty, full};
  endfunction

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            irq_q, irq_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            push_req_s;
  logic            push_s;
  logic            bit_end_s;
  logic            unused_wdata_s;

  assign empty_s        = (count_q == CNT_ZERO);
  assign full_s         = (count_q == CNT_FULL);
  assign unused_wdata_s = ^bus.wdata[31:8];

  // Transmit FSM: next state, baud counter, bit index, shift register, txd.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
    bit_end_s = (cnt_q == 16'd0);
    if (bit_end_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          cnt_d   = DIV_M1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          cnt_d   = DIV_M1;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = DIV_M1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = DIV_M1;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        // Popping on the last stop cycle gives back-to-back frames with no gap.
        if (bit_end_s) begin
          cnt_d = DIV_M1;
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // txd is derived from the next state so the pin changes on the entry edge.
    case (state_d)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = even_parity(shift_d);
`endif
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO pointers/count, overflow flag, load data and interrupt next-state.
  always_comb begin
    push_req_s = bus.we & (bus.addr == 2'd0);
    // A full FIFO still accepts the store when the transmitter pops this cycle.
    push_s     = push_req_s & (~full_s | pop_s);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (push_req_s && !push_s) begin
      ovf_d = 1'b1;
    end else if (bus.we && (bus.addr == 2'd1) && bus.wdata[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    // Loads see pre-store state because the status word uses _q values only.
    if (bus.re) begin
      if (bus.addr == 2'd1) begin
        rdata_d = status_word(full_s, empty_s, (state_q != S_IDLE), ovf_q,
                              PAR_EN, 8'(count_q));
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      rdata_d = rdata_q;
    end

    irq_d = (count_d == CNT_ZERO) & (state_d == S_IDLE);
  end

  // State and control registers with asynchronous reset.
  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      txd_q    <= 1'b1;
      irq_q    <= 1'b1;
      rdata_q  <= 32'h0000_0000;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge sysclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.wdata[7:0];
    end
  end

  assign txd       = txd_q;
  assign irq       = irq_q;
  assign bus.rdata = rdata_q;

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter sitting directly downstream of the CPU core's data-memory port. It consumes CPU store transactions into a small byte FIFO and serialises each byte onto a single TX pin as 8N1 (optionally 8E1) frames. It provides a status word for software polling. It runs entirely in the CPU clock domain and is instantiated next to `CPUTop`'s data bus decoder.

## Interface

Parameters:
- `DIVISOR`, 868: clock cycles per bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, 2..64.

Ports:
- `sysclk`  in  1  system clock, rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `we`  in  1  store strobe, one cycle per access.
- `re`  in  1  load strobe, one cycle per access.
- `addr`  in  2  word offset: 0 = TXDATA, 1 = STATUS; 2–3 reserved.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, registered.
- `txd`  out  1  serial output, idle high.
- `irq`  out  1  level interrupt: FIFO empty and transmitter idle.

## Operation

- TXDATA write (`we`, addr 0): `wdata[7:0]` is pushed to the FIFO. Upper bits are ignored.
  - If the FIFO is full with no pop in the same cycle, the byte is dropped and sticky `ovf` is set.
- STATUS read (`re`, addr 1) returns:
  - bit0 `full`
  - bit1 `empty`
  - bit2 `busy` (FSM not IDLE)
  - bit3 `ovf`
  - bits[11:8] FIFO count, saturating at 15
  - all other bits 0
- STATUS write with `wdata[3]=1` clears `ovf`. Other bits are ignored.
- Reads of addr 0, 2, 3 return 0. Writes to addr 2, 3 are ignored.
- FSM states:
  - IDLE (`txd`=1): if FIFO non-empty, pop the head into the shift register and go to START.
  - START (`txd`=0, DIVISOR cycles): then DATA with bit index 0.
  - DATA (`txd`=shift[idx], LSB first, DIVISOR cycles per bit): after idx 7, go to PARITY when the macro is defined, else STOP.
  - PARITY (`txd`=^byte for even parity, DIVISOR cycles): then STOP.
  - STOP (`txd`=1, DIVISOR cycles): at the final cycle, if FIFO non-empty, pop and go straight to START (no idle gap); else go to IDLE.
- Baud counter: 16 bits, reloads to DIVISOR-1 on every state entry and decrements to 0. The bit ends when the counter reaches 0.
- Simultaneous push and pop: both happen and count is unchanged. Push to a full FIFO with a pop in the same cycle is accepted.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- `irq` = `empty` & IDLE, registered.

## Timing

- Reset values:
  - `txd`=1, `rdata`=0, `irq`=1
  - FSM=IDLE, FIFO empty, `ovf`=0, counter=0
- Reset mid-frame: `txd` goes to 1 asynchronously, the partial frame is abandoned, and FIFO contents are discarded.
- Write at edge N makes the FIFO non-empty at N. The IDLE pop occurs at edge N+1, and `txd` falls after edge N+1.
- Frame length is 10·DIVISOR cycles (11·DIVISOR with parity). Back-to-back frames have no gap.
- `rdata` is valid the cycle after `re` and holds until the next `re`.
- A STATUS read in the same cycle as a write reflects pre-write state.

## Configuration

- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in, an even parity bit is emitted after data bit 7, frames are 11 bits, and STATUS bit4 reads 1.
- Not defined: the PARITY state and parity logic are absent, frames are 8N1, and STATUS bit4 reads 0.

## Test plan

All scenarios use DIVISOR=4 and FIFO_DEPTH=4.

1. Reset and idle.
   - Stimulus: hold `nrst` low 2 cycles, release, read STATUS.
   - Required: `rdata`=0x0000_0002, `txd`=1, `irq`=1.
2. Single byte.
   - Stimulus: write 0xA5 to TXDATA.
   - Required: `txd` low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. Total 40 cycles from pop, with `irq` low throughout the frame.
3. Back-to-back.
   - Stimulus: write 0x55 and 0x0F in consecutive cycles.
   - Required: the second start bit begins immediately after the first stop bit, giving 80 contiguous cycles.
4. Overflow.
   - Stimulus: write 6 bytes in consecutive cycles.
   - Required: first byte popped, 4 queued, one dropped. STATUS reads bit3=1, bit0=1, count=4. Writing 0x8 to STATUS clears `ovf`. Exactly 5 frames appear on `txd`.
5. Reset mid-frame.
   - Stimulus: assert `nrst` during the DATA state.
   - Required: `txd`=1 immediately and STATUS=0x2 after release.
6. Parity.
   - Stimulus: with `UART_TX_PARITY_EN`, write 0x07.
   - Required: parity bit = 1 and frame length = 44 cycles.
